mul_float64_core: RTL and testbench

//  Multiply stage upstream of the float64 round-and-pack stage. Unpacks operands a,b,

---
 rtl/mul_float64_core_if.sv | 29 ++
 rtl/mul_float64_core.sv | 208 ++++++++++++++++++++
 tb/tb_mul_float64_core.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mul_float64_core_if.sv
// rtl/mul_float64_core_if.sv - handshake and operand/result bundle for mul_float64_core
interface mul_float64_core_if;
  logic        ap_start;
  logic        ap_done;
  logic        ap_ready;
  logic        ap_idle;
  logic [63:0] a;
  logic [63:0] b;
  logic [31:0] float_exception_flag_i;
  logic [31:0] float_exception_flag_o;
  logic        float_exception_flag_o_ap_vld;
  logic        special_vld;
  logic [63:0] special_result;
  logic        zSign;
  logic [12:0] zExp;
  logic [63:0] zSig;

  modport master (
    output ap_start, a, b, float_exception_flag_i,
    input  ap_done, ap_ready, ap_idle, float_exception_flag_o, float_exception_flag_o_ap_vld,
    input  special_vld, special_result, zSign, zExp, zSig
  );

  modport slave (
    input  ap_start, a, b, float_exception_flag_i,
    output ap_done, ap_ready, ap_idle, float_exception_flag_o, float_exception_flag_o_ap_vld,
    output special_vld, special_result, zSign, zExp, zSig
  );
endinterface

// File: rtl/mul_float64_core.sv
// rtl/mul_float64_core.sv - float64 multiply front end feeding round-and-pack
// MUL_DAZ_EN: when defined, subnormal operands are taken as signed zero and no normalisation is built.
module mul_float64_core #(
  parameter int          BIAS    = 1023,
  parameter logic [63:0] DEF_NAN = 64'hFFF8000000000000
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  mul_float64_core_if.slave bus
);

  localparam logic [12:0] BIAS13    = 13'(BIAS);
  localparam logic [63:0] QUIET_BIT = 64'h0008000000000000;

`ifdef MUL_DAZ_EN
  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_MUL, S_ADJ, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_NORM_A, S_NORM_B, S_MUL, S_ADJ, S_DONE} state_t;
`endif

  state_t       state;
  logic [63:0]  opa, opb;
  logic [105:0] mcand;
  logic [52:0]  mplier;
  logic [105:0] prod;
  logic [12:0]  exp_a, exp_b;
  logic [5:0]   cnt;

  logic         done_q, idle_q, invalid_q, spec_vld_q, zsign_q;
  logic [63:0]  spec_res_q, zsig_q;
  logic [12:0]  zexp_q;

  logic [10:0] a_exp, b_exp;
  logic [51:0] a_frac, b_frac;
  logic        a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  logic        z_sign;

  assign a_exp  = opa[62:52];
  assign b_exp  = opb[62:52];
  assign a_frac = opa[51:0];
  assign b_frac = opb[51:0];
  assign z_sign = opa[63] ^ opb[63];

  assign a_nan  = (a_exp == 11'h7FF) && (a_frac != 52'd0);
  assign b_nan  = (b_exp == 11'h7FF) && (b_frac != 52'd0);
  assign a_snan = a_nan && !a_frac[51];
  assign b_snan = b_nan && !b_frac[51];
  assign a_inf  = (a_exp == 11'h7FF) && (a_frac == 52'd0);
  assign b_inf  = (b_exp == 11'h7FF) && (b_frac == 52'd0);

`ifdef MUL_DAZ_EN
  assign a_zero = (a_exp == 11'd0);
  assign b_zero = (b_exp == 11'd0);
`else
  logic a_sub, b_sub;
  assign a_zero = (a_exp == 11'd0) && (a_frac == 52'd0);
  assign b_zero = (b_exp == 11'd0) && (b_frac == 52'd0);
  assign a_sub  = (a_exp == 11'd0) && (a_frac != 52'd0);
  assign b_sub  = (b_exp == 11'd0) && (b_frac != 52'd0);
`endif

  logic        spec_hit, spec_inv;
  logic [63:0] spec_res;

  // NaN beats Inf beats zero; invalid comes from sNaN inputs or Inf x 0.
  always_comb begin
    spec_hit = 1'b0;
    spec_inv = 1'b0;
    spec_res = 64'd0;
    if (a_nan || b_nan) begin
      spec_hit = 1'b1;
      spec_res = a_nan ? (opa | QUIET_BIT) : (opb | QUIET_BIT);
      spec_inv = a_snan || b_snan;
    end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
      spec_hit = 1'b1;
      spec_res = DEF_NAN;
      spec_inv = 1'b1;
    end else if (a_inf || b_inf) begin
      spec_hit = 1'b1;
      spec_res = {z_sign, 11'h7FF, 52'd0};
    end else if (a_zero || b_zero) begin
      spec_hit = 1'b1;
      spec_res = {z_sign, 63'd0};
    end
  end

  logic [12:0] e_sum, zexp_n;
  logic [63:0] zsig_n;
  logic        sticky;

  // Bit 105 set means the product is in [2,4); otherwise it sits one place lower.
  always_comb begin
    e_sum  = exp_a + exp_b - BIAS13;
    sticky = |prod[41:0];
    zsig_n = {prod[105:43], prod[42] | sticky};
    zexp_n = prod[105] ? e_sum : (e_sum - 13'd1);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state      <= S_IDLE;
      opa        <= 64'd0;
      opb        <= 64'd0;
      mcand      <= 106'd0;
      mplier     <= 53'd0;
      prod       <= 106'd0;
      exp_a      <= 13'd0;
      exp_b      <= 13'd0;
      cnt        <= 6'd0;
      done_q     <= 1'b0;
      idle_q     <= 1'b1;
      invalid_q  <= 1'b0;
      spec_vld_q <= 1'b0;
      spec_res_q <= 64'd0;
      zsign_q    <= 1'b0;
      zexp_q     <= 13'd0;
      zsig_q     <= 64'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.ap_start) begin
            opa    <= bus.a;
            opb    <= bus.b;
            idle_q <= 1'b0;
            state  <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          mcand  <= {53'd0, (a_exp != 11'd0), a_frac};
          mplier <= {(b_exp != 11'd0), b_frac};
          exp_a  <= (a_exp == 11'd0) ? 13'd1 : {2'b00, a_exp};
          exp_b  <= (b_exp == 11'd0) ? 13'd1 : {2'b00, b_exp};
          prod   <= 106'd0;
          cnt    <= 6'd0;
          if (spec_hit) begin
            spec_vld_q <= 1'b1;
            spec_res_q <= spec_res;
            invalid_q  <= spec_inv;
            zsign_q    <= z_sign;
            zexp_q     <= 13'd0;
            zsig_q     <= 64'd0;
            done_q     <= 1'b1;
            state      <= S_DONE;
`ifndef MUL_DAZ_EN
          end else if (a_sub) begin
            state <= S_NORM_A;
          end else if (b_sub) begin
            state <= S_NORM_B;
`endif
          end else begin
            state <= S_MUL;
          end
        end
`ifndef MUL_DAZ_EN
        S_NORM_A: begin
          mcand <= mcand << 1;
          exp_a <= exp_a - 13'd1;
          if (mcand[51]) state <= b_sub ? S_NORM_B : S_MUL;
        end
        S_NORM_B: begin
          mplier <= mplier << 1;
          exp_b  <= exp_b - 13'd1;
          if (mplier[51]) state <= S_MUL;
        end
`endif
        S_MUL: begin
          if (mplier[0]) prod <= prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 6'd1;
          if (cnt == 6'd52) state <= S_ADJ;
        end
        S_ADJ: begin
          spec_vld_q <= 1'b0;
          spec_res_q <= 64'd0;
          invalid_q  <= 1'b0;
          zsign_q    <= z_sign;
          zexp_q     <= zexp_n;
          zsig_q     <= zsig_n;
          done_q     <= 1'b1;
          state      <= S_DONE;
        end
        S_DONE: begin
          done_q <= 1'b0;
          idle_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: begin
          done_q <= 1'b0;
          idle_q <= 1'b1;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ap_done                       = done_q;
  assign bus.ap_ready                      = done_q;
  assign bus.ap_idle                       = idle_q;
  assign bus.special_vld                   = spec_vld_q;
  assign bus.special_result                = spec_res_q;
  assign bus.zSign                         = zsign_q;
  assign bus.zExp                          = zexp_q;
  assign bus.zSig                          = zsig_q;
  assign bus.float_exception_flag_o        = bus.float_exception_flag_i | {27'd0, invalid_q, 4'd0};
  assign bus.float_exception_flag_o_ap_vld = done_q & invalid_q;

endmodule

// File: tb/tb_mul_float64_core.sv
// tb/tb_mul_float64_core.sv - directed self-checking bench for mul_float64_core
module tb_mul_float64_core;
  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   lat;

  localparam logic [31:0] FLAGS = 32'h0000_0101;

  mul_float64_core_if bus ();

  mul_float64_core dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus.slave)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Accept happens at the first rising edge; lat counts cycles from there to the ap_done cycle.
  task automatic run_op(input logic [63:0] ia, input logic [63:0] ib, output int l);
    @(negedge ap_clk);
    bus.a = ia;
    bus.b = ib;
    bus.ap_start = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    bus.ap_start = 1'b0;
    l = 1;
    while (!bus.ap_done && l < 400) begin
      @(negedge ap_clk);
      l++;
    end
  endtask

  initial begin
    bus.ap_start = 1'b0;
    bus.a = 64'd0;
    bus.b = 64'd0;
    bus.float_exception_flag_i = FLAGS;
    repeat (3) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);

    chk("rst_idle", 64'(bus.ap_idle), 64'd1);
    chk("rst_done", 64'(bus.ap_done), 64'd0);
    chk("rst_zsig", bus.zSig, 64'd0);
    chk("rst_flag", 64'(bus.float_exception_flag_o), 64'(FLAGS));

    // 1.0 x 1.0, with a start raised in the DONE cycle that must be dropped
    run_op(64'h3FF0000000000000, 64'h3FF0000000000000, lat);
    chk("t1_lat", 64'(lat), 64'd56);
    chk("t1_zexp", 64'(bus.zExp), 64'd1022);
    chk("t1_zsig", bus.zSig, 64'h4000000000000000);
    chk("t1_zsign", 64'(bus.zSign), 64'd0);
    chk("t1_vld", 64'(bus.special_vld), 64'd0);
    chk("t1_ready", 64'(bus.ap_ready), 64'd1);
    bus.ap_start = 1'b1;
    @(negedge ap_clk);
    bus.ap_start = 1'b0;
    chk("t1_pulse", 64'(bus.ap_done), 64'd0);
    chk("t1_idle_after", 64'(bus.ap_idle), 64'd1);
    @(negedge ap_clk);
    chk("t1_no_queue", 64'(bus.ap_idle), 64'd1);

    // 1.5 x 1.5
    run_op(64'h3FF8000000000000, 64'h3FF8000000000000, lat);
    chk("t2_lat", 64'(lat), 64'd56);
    chk("t2_zexp", 64'(bus.zExp), 64'd1023);
    chk("t2_zsig", bus.zSig, 64'h9000000000000000);

    // Inf x 0
    run_op(64'h7FF0000000000000, 64'h0000000000000000, lat);
    chk("t3_lat", 64'(lat), 64'd2);
    chk("t3_res", bus.special_result, 64'hFFF8000000000000);
    chk("t3_vld", 64'(bus.special_vld), 64'd1);
    chk("t3_flag", 64'(bus.float_exception_flag_o), 64'(FLAGS | 32'd16));
    chk("t3_flag_vld", 64'(bus.float_exception_flag_o_ap_vld), 64'd1);

    // sNaN x 1.0
    run_op(64'h7FF0000000000001, 64'h3FF0000000000000, lat);
    chk("t4_lat", 64'(lat), 64'd2);
    chk("t4_res", bus.special_result, 64'h7FF8000000000001);
    chk("t4_flag", 64'(bus.float_exception_flag_o), 64'(FLAGS | 32'd16));

    // 1.0 x qNaN: quiet, no invalid
    run_op(64'h3FF0000000000000, 64'h7FF8000000000000, lat);
    chk("qnan_res", bus.special_result, 64'h7FF8000000000000);
    chk("qnan_flag_vld", 64'(bus.float_exception_flag_o_ap_vld), 64'd0);
    chk("qnan_flag", 64'(bus.float_exception_flag_o), 64'(FLAGS));

    // -Inf x 2.0 and 0 x -2.0
    run_op(64'hFFF0000000000000, 64'h4000000000000000, lat);
    chk("ninf_res", bus.special_result, 64'hFFF0000000000000);
    run_op(64'h0000000000000000, 64'hC000000000000000, lat);
    chk("nzero_res", bus.special_result, 64'h8000000000000000);

    // Smallest subnormal x 1.0
    run_op(64'h0000000000000001, 64'h3FF0000000000000, lat);
`ifdef MUL_DAZ_EN
    chk("t5_lat", 64'(lat), 64'd2);
    chk("t5_res", bus.special_result, 64'd0);
    chk("t5_vld", 64'(bus.special_vld), 64'd1);
`else
    chk("t5_lat", 64'(lat), 64'd108);
    chk("t5_zexp", 64'(bus.zExp), 64'h1FCC);
    chk("t5_zsig", bus.zSig, 64'h4000000000000000);
    chk("t5_vld", 64'(bus.special_vld), 64'd0);
`endif

    // -2.0 x 3.0 = -6.0
    run_op(64'hC000000000000000, 64'h4008000000000000, lat);
    chk("neg_lat", 64'(lat), 64'd56);
    chk("neg_zsign", 64'(bus.zSign), 64'd1);
    chk("neg_zexp", 64'(bus.zExp), 64'd1024);
    chk("neg_zsig", bus.zSig, 64'h6000000000000000);

    // Reset during MUL cycle 20 (cycle 21 after accept)
    @(negedge ap_clk);
    bus.a = 64'h3FF0000000000000;
    bus.b = 64'h3FF0000000000000;
    bus.ap_start = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    bus.ap_start = 1'b0;
    repeat (20) @(negedge ap_clk);
    ap_rst_n = 1'b0;
    #1;
    chk("t6_idle", 64'(bus.ap_idle), 64'd1);
    chk("t6_zsig", bus.zSig, 64'd0);
    chk("t6_zexp", 64'(bus.zExp), 64'd0);
    chk("t6_zsign", 64'(bus.zSign), 64'd0);
    chk("t6_vld", 64'(bus.special_vld), 64'd0);
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge ap_clk);
      if (bus.ap_done) lat++;
    end
    chk("t6_no_done", 64'(lat), 64'd0);
    run_op(64'h3FF0000000000000, 64'h3FF0000000000000, lat);
    chk("t6_relat", 64'(lat), 64'd56);
    chk("t6_rezsig", bus.zSig, 64'h4000000000000000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
